// File: rtl/gol_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gol_pkg
//  Description : Shared types and helpers for the Game-of-Life engine:
//                the engine state encoding and the flat grid index of a cell.
//  Revision    : 1.0 - initial release
// ============================================================================
package gol_pkg;

    // Engine control states. The encodings are fixed so the state register
    // width is explicit.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } gol_state_e;

    // Flat bit index of (row, col) in a row-major grid with 'cols' columns.
    function automatic int cell_idx(input int r, input int c, input int cols);
        return r * cols + c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gol_next.sv
`default_nettype none
// ============================================================================
//  Module      : gol_next
//  Description : Purely combinational next-generation function for a
//                ROWS x COLS Game-of-Life grid using rule B3/S23.
//  Ports       : grid_in  - current generation, bit r*COLS+c = (r,c)
//                wrap     - 1: toroidal edges, 0: outside cells are dead
//                grid_out - next generation
//  Revision    : 1.0 - initial release
// ============================================================================
module gol_next
    import gol_pkg::*;
#(
    parameter int ROWS = 8,
    parameter int COLS = 8
) (
    input  logic [ROWS*COLS-1:0] grid_in,
    input  logic                 wrap,
    output logic [ROWS*COLS-1:0] grid_out
);

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            // One bit per position of the 3x3 window; the centre bit is tied
            // low so that summing all nine gives the neighbour count.
            logic [8:0] w_nb;
            logic [3:0] w_count;

            for (genvar dr = 0; dr < 3; dr++) begin : g_dr
                for (genvar dc = 0; dc < 3; dc++) begin : g_dc
                    localparam int c_RR  = r + dr - 1;
                    localparam int c_CC  = c + dc - 1;
                    // Wrapped coordinates are always a legal index; when the
                    // neighbour lies off-grid the wrap input gates it.
                    localparam int c_RW  = (c_RR + ROWS) % ROWS;
                    localparam int c_CW  = (c_CC + COLS) % COLS;
                    localparam bit c_INSIDE = (c_RR >= 0) && (c_RR < ROWS) &&
                                              (c_CC >= 0) && (c_CC < COLS);
                    localparam int c_IDX = cell_idx(c_RW, c_CW, COLS);

                    if (dr == 1 && dc == 1) begin : g_self
                        assign w_nb[dr*3+dc] = 1'b0;
                    end else if (c_INSIDE) begin : g_in
                        assign w_nb[dr*3+dc] = grid_in[c_IDX];
                    end else begin : g_edge
                        assign w_nb[dr*3+dc] = wrap & grid_in[c_IDX];
                    end
                end
            end

            always_comb begin
                w_count = 4'd0;
                for (int k = 0; k < 9; k++) begin
                    w_count = w_count + {3'd0, w_nb[k]};
                end
            end

            localparam int c_SELF = cell_idx(r, c, COLS);

            // Born with exactly 3, survives with 2 or 3.
            assign grid_out[c_SELF] = (w_count == 4'd3) |
                                      (grid_in[c_SELF] & (w_count == 4'd2));
        end
    end

endmodule
`default_nettype wire

// File: rtl/gol_engine.sv
`default_nettype none
// ============================================================================
//  Module      : gol_engine
//  Description : Parametrised Game-of-Life engine. Holds the grid, evolves
//                it under run/step control, counts generations and halts on
//                a generation limit or on a stable pattern.
//  Ports       : clk, reset (async, active-high)
//                load/seed       - copy seed into grid, return to IDLE
//                run/step        - continuous run level / single-step pulse
//                wrap            - toroidal (1) or dead-boundary (0) edges
//                halt_on_stable  - halt when a generation repeats
//                max_gen         - generation limit, 0 = unlimited
//                grid, gen_count, stable, extinct, done, busy - status
//  Revision    : 1.0 - initial release
// ============================================================================
module gol_engine
    import gol_pkg::*;
#(
    parameter int ROWS  = 8,
    parameter int COLS  = 8,
    parameter int GEN_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic [ROWS*COLS-1:0] seed,
    input  logic                 run,
    input  logic                 step,
    input  logic                 wrap,
    input  logic                 halt_on_stable,
    input  logic [GEN_W-1:0]     max_gen,
    output logic [ROWS*COLS-1:0] grid,
    output logic [GEN_W-1:0]     gen_count,
    output logic                 stable,
    output logic                 extinct,
    output logic                 done,
    output logic                 busy
);

    localparam int c_CELLS = ROWS * COLS;

    logic [c_CELLS-1:0] r_grid;
    logic [c_CELLS-1:0] w_next;
    logic [GEN_W-1:0]   r_gen;
    logic [GEN_W-1:0]   w_gen_inc;
    logic [GEN_W:0]     w_gen_plus1;
    logic               r_stable;
    logic               r_extinct;
    gol_state_e         r_state;
    gol_state_e         w_state_next;
    logic               w_evolve;
    logic               w_same;
    logic               w_limit_hit;
    logic               w_halt;

    gol_next #(
        .ROWS (ROWS),
        .COLS (COLS)
    ) u_next (
        .grid_in  (r_grid),
        .wrap     (wrap),
        .grid_out (w_next)
    );

    assign w_same    = (w_next == r_grid);
    assign w_gen_inc = (&r_gen) ? r_gen : r_gen + GEN_W'(1);

    // Limit compare is done one bit wider so a saturated counter cannot
    // wrap around and miss the limit.
    assign w_gen_plus1 = {1'b0, r_gen} + {{GEN_W{1'b0}}, 1'b1};
    assign w_limit_hit = (max_gen != '0) && (w_gen_plus1 >= {1'b0, max_gen});
    assign w_halt      = w_limit_hit || (halt_on_stable && w_same);

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_evolve     = 1'b0;
        if (load) begin
            w_state_next = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    // Entering RUN costs one edge with no evolve.
                    if (run) begin
                        w_state_next = RUN;
                    end else if (step) begin
                        w_evolve = 1'b1;
                    end
                end
                RUN: begin
                    if (!run) begin
                        w_state_next = IDLE;
                    end else begin
                        w_evolve = 1'b1;
                        if (w_halt) begin
                            w_state_next = HALT;
                        end
                    end
                end
                HALT: begin
                    w_state_next = HALT;
                end
                default: begin
                    w_state_next = IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Grid and status registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_grid    <= '0;
            r_gen     <= '0;
            r_stable  <= 1'b0;
            r_extinct <= 1'b0;
        end else if (load) begin
            r_grid    <= seed;
            r_gen     <= '0;
            r_stable  <= 1'b0;
            r_extinct <= 1'b0;
        end else if (w_evolve) begin
            r_grid    <= w_next;
            r_gen     <= w_gen_inc;
            r_stable  <= w_same;
            r_extinct <= (w_next == '0);
        end
    end

    assign grid      = r_grid;
    assign gen_count = r_gen;
    assign stable    = r_stable;
    assign extinct   = r_extinct;
    assign busy      = (r_state == RUN);
    assign done      = (r_state == HALT);

endmodule
`default_nettype wire

// File: tb/tb_gol_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gol_engine
//  Description : Directed self-checking bench for gol_engine (8x8 grid,
//                16-bit counter) plus a 4-bit counter instance for
//                saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gol_engine;

    localparam logic [63:0] c_BLINK_H = (64'd1 << 26) | (64'd1 << 27) | (64'd1 << 28);
    localparam logic [63:0] c_BLINK_V = (64'd1 << 19) | (64'd1 << 27) | (64'd1 << 35);
    localparam logic [63:0] c_BLOCK   = (64'd1 << 9) | (64'd1 << 10) | (64'd1 << 17) | (64'd1 << 18);
    localparam logic [63:0] c_GLIDER  = (64'd1 << 1) | (64'd1 << 10) | (64'd1 << 16) |
                                        (64'd1 << 17) | (64'd1 << 18);
    localparam logic [63:0] c_SINGLE  = 64'd1;

    logic        clk;
    logic        reset;
    logic        load;
    logic [63:0] seed;
    logic        run;
    logic        step;
    logic        wrap;
    logic        halt_on_stable;
    logic [15:0] max_gen;
    logic [63:0] grid;
    logic [15:0] gen_count;
    logic        stable;
    logic        extinct;
    logic        done;
    logic        busy;

    logic        load4;
    logic        run4;
    logic        step4;
    logic        hos4;
    logic [3:0]  max_gen4;
    logic [63:0] grid4;
    logic [3:0]  gen_count4;
    logic        stable4;
    logic        extinct4;
    logic        done4;
    logic        busy4;

    int n_cmp;
    int n_fail;

    gol_engine #(.ROWS(8), .COLS(8), .GEN_W(16)) dut (
        .clk            (clk),
        .reset          (reset),
        .load           (load),
        .seed           (seed),
        .run            (run),
        .step           (step),
        .wrap           (wrap),
        .halt_on_stable (halt_on_stable),
        .max_gen        (max_gen),
        .grid           (grid),
        .gen_count      (gen_count),
        .stable         (stable),
        .extinct        (extinct),
        .done           (done),
        .busy           (busy)
    );

    gol_engine #(.ROWS(8), .COLS(8), .GEN_W(4)) dut4 (
        .clk            (clk),
        .reset          (reset),
        .load           (load4),
        .seed           (seed),
        .run            (run4),
        .step           (step4),
        .wrap           (wrap),
        .halt_on_stable (hos4),
        .max_gen        (max_gen4),
        .grid           (grid4),
        .gen_count      (gen_count4),
        .stable         (stable4),
        .extinct        (extinct4),
        .done           (done4),
        .busy           (busy4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [63:0] s);
        seed = s;
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic do_step();
        step = 1'b1;
        tick();
        step = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #1 reset = 1'b1;
        #1;
        n_cmp++; if (grid !== 64'd0) begin n_fail++; $display("FAIL reset_grid: got %h want %h", grid, 64'd0); end
        n_cmp++; if (gen_count !== 16'd0) begin n_fail++; $display("FAIL reset_gen: got %0d want 0", gen_count); end
        n_cmp++; if ({stable, extinct, done, busy} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags: got %b want 0000", {stable, extinct, done, busy}); end
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_blinker();
        wrap = 1'b0;
        do_load(c_BLINK_H);
        n_cmp++; if (grid !== c_BLINK_H) begin n_fail++; $display("FAIL blink_load: got %h want %h", grid, c_BLINK_H); end
        do_step();
        n_cmp++; if (grid !== c_BLINK_V) begin n_fail++; $display("FAIL blink_step1: got %h want %h", grid, c_BLINK_V); end
        n_cmp++; if (gen_count !== 16'd1) begin n_fail++; $display("FAIL blink_gen1: got %0d want 1", gen_count); end
        n_cmp++; if (stable !== 1'b0) begin n_fail++; $display("FAIL blink_stable: got %b want 0", stable); end
        do_step();
        n_cmp++; if (grid !== c_BLINK_H) begin n_fail++; $display("FAIL blink_step2: got %h want %h", grid, c_BLINK_H); end
        n_cmp++; if (gen_count !== 16'd2) begin n_fail++; $display("FAIL blink_gen2: got %0d want 2", gen_count); end
        tick();
        tick();
        n_cmp++; if (gen_count !== 16'd2 || grid !== c_BLINK_H) begin n_fail++; $display("FAIL idle_hold: got gen %0d grid %h want gen 2 grid %h", gen_count, grid, c_BLINK_H); end
    endtask

    task automatic test_block_stable();
        do_load(c_BLOCK);
        halt_on_stable = 1'b1;
        run = 1'b1;
        tick();
        n_cmp++; if (busy !== 1'b1 || gen_count !== 16'd0) begin n_fail++; $display("FAIL block_enter_run: got busy %b gen %0d want busy 1 gen 0", busy, gen_count); end
        tick();
        n_cmp++; if (grid !== c_BLOCK) begin n_fail++; $display("FAIL block_grid: got %h want %h", grid, c_BLOCK); end
        n_cmp++; if ({stable, done, busy} !== 3'b110) begin n_fail++; $display("FAIL block_flags: got stable/done/busy %b want 110", {stable, done, busy}); end
        n_cmp++; if (gen_count !== 16'd1) begin n_fail++; $display("FAIL block_gen: got %0d want 1", gen_count); end
        step = 1'b1;
        tick();
        tick();
        tick();
        step = 1'b0;
        n_cmp++; if (gen_count !== 16'd1 || done !== 1'b1) begin n_fail++; $display("FAIL block_hold: got gen %0d done %b want gen 1 done 1", gen_count, done); end
        run = 1'b0;
        halt_on_stable = 1'b0;
        do_load(64'd0);
        n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL halt_exit: got done %b busy %b want 0 0", done, busy); end
    endtask

    task automatic test_single_cell();
        for (int w = 0; w < 2; w++) begin
            wrap = (w == 1);
            do_load(c_SINGLE);
            do_step();
            n_cmp++; if (grid !== 64'd0) begin n_fail++; $display("FAIL single_grid wrap=%0d: got %h want 0", w, grid); end
            n_cmp++; if ({extinct, stable} !== 2'b10) begin n_fail++; $display("FAIL single_flags wrap=%0d: got extinct/stable %b want 10", w, {extinct, stable}); end
            n_cmp++; if (gen_count !== 16'd1) begin n_fail++; $display("FAIL single_gen wrap=%0d: got %0d want 1", w, gen_count); end
        end
    endtask

    task automatic test_glider_torus();
        wrap = 1'b1;
        max_gen = 16'd32;
        do_load(c_GLIDER);
        run = 1'b1;
        for (int i = 0; i < 100 && !done; i++) begin
            tick();
        end
        n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL glider_done: got %b want 1 (cycle budget expired)", done); end
        n_cmp++; if (gen_count !== 16'd32) begin n_fail++; $display("FAIL glider_gen: got %0d want 32", gen_count); end
        n_cmp++; if (grid !== c_GLIDER) begin n_fail++; $display("FAIL glider_grid: got %h want %h", grid, c_GLIDER); end
        tick();
        n_cmp++; if (gen_count !== 16'd32 || busy !== 1'b0) begin n_fail++; $display("FAIL glider_frozen: got gen %0d busy %b want 32 0", gen_count, busy); end
        run = 1'b0;
        max_gen = 16'd0;
        wrap = 1'b0;
        do_load(64'd0);
    endtask

    task automatic test_load_mid_run();
        wrap = 1'b0;
        do_load(c_BLINK_H);
        run = 1'b1;
        repeat (5) tick();
        n_cmp++; if (gen_count !== 16'd4 || grid !== c_BLINK_H || busy !== 1'b1) begin n_fail++; $display("FAIL run5: got gen %0d grid %h busy %b want 4 %h 1", gen_count, grid, busy, c_BLINK_H); end
        seed = c_BLOCK;
        load = 1'b1;
        tick();
        load = 1'b0;
        n_cmp++; if (grid !== c_BLOCK || gen_count !== 16'd0 || busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL load_midrun: got grid %h gen %0d busy %b done %b want %h 0 0 0", grid, gen_count, busy, done, c_BLOCK); end
        tick();
        n_cmp++; if (busy !== 1'b1 || gen_count !== 16'd0) begin n_fail++; $display("FAIL rerun_enter: got busy %b gen %0d want 1 0", busy, gen_count); end
        tick();
        n_cmp++; if (gen_count !== 16'd1 || stable !== 1'b1) begin n_fail++; $display("FAIL rerun_evolve: got gen %0d stable %b want 1 1", gen_count, stable); end
        #3 reset = 1'b1;
        #1;
        n_cmp++; if (grid !== 64'd0 || gen_count !== 16'd0 || {stable, extinct, done, busy} !== 4'b0000) begin n_fail++; $display("FAIL async_reset: got grid %h gen %0d flags %b want 0 0 0000", grid, gen_count, {stable, extinct, done, busy}); end
        run = 1'b0;
        #1 reset = 1'b0;
        tick();
    endtask

    task automatic test_saturation();
        wrap = 1'b0;
        seed = c_BLINK_H;
        load4 = 1'b1;
        tick();
        load4 = 1'b0;
        run4 = 1'b1;
        repeat (21) tick();
        n_cmp++; if (gen_count4 !== 4'd15) begin n_fail++; $display("FAIL sat_gen: got %0d want 15", gen_count4); end
        n_cmp++; if (grid4 !== c_BLINK_H || busy4 !== 1'b1) begin n_fail++; $display("FAIL sat_grid_even: got %h busy %b want %h 1", grid4, busy4, c_BLINK_H); end
        tick();
        n_cmp++; if (grid4 !== c_BLINK_V || gen_count4 !== 4'd15) begin n_fail++; $display("FAIL sat_grid_odd: got %h gen %0d want %h 15", grid4, gen_count4, c_BLINK_V); end
        run4 = 1'b0;
        tick();
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        reset = 1'b0;
        load = 1'b0;
        seed = 64'd0;
        run = 1'b0;
        step = 1'b0;
        wrap = 1'b0;
        halt_on_stable = 1'b0;
        max_gen = 16'd0;
        load4 = 1'b0;
        run4 = 1'b0;
        step4 = 1'b0;
        hos4 = 1'b0;
        max_gen4 = 4'd0;

        test_reset();
        test_blinker();
        test_block_stable();
        test_single_cell();
        test_glider_torus();
        test_load_mid_run();
        test_saturation();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
